// File: rtl/aurora_lane_pkg.sv
// Shared types and helpers for the Aurora lane mapper.
package aurora_lane_pkg;

   localparam int unsigned MAX_LANES = 8;
   localparam int unsigned IDX_W     = 4;

   typedef enum logic [1:0] {
      ST_ACTIVE = 2'd0,
      ST_CHECK  = 2'd1,
      ST_BLANK  = 2'd2
   } lane_state_e;

   // Lane map widened to the largest supported lane count, one field per lane.
   typedef logic [MAX_LANES-1:0][IDX_W-1:0] lane_vec_t;

   // Identity map: lane i sourced from lane i; unused upper fields are zero.
   function automatic lane_vec_t identity_map(input int unsigned num_lanes);
      lane_vec_t m;
      m = '0;
      for (int unsigned i = 0; i < MAX_LANES; i++) begin
         if (i < num_lanes) m[i] = IDX_W'(i);
      end
      return m;
   endfunction

   // True when the first num_lanes fields form a permutation of 0..num_lanes-1.
   function automatic logic map_is_perm(input lane_vec_t m, input int unsigned num_lanes);
      logic ok;
      ok = 1'b1;
      for (int unsigned i = 0; i < MAX_LANES; i++) begin
         if (i < num_lanes) begin
            if (32'(m[i]) >= num_lanes) ok = 1'b0;
            for (int unsigned j = 0; j < MAX_LANES; j++) begin
               if ((j < i) && (m[j] == m[i])) ok = 1'b0;
            end
         end
      end
      return ok;
   endfunction

endpackage

// File: rtl/aurora_lane_xbar.sv
// Combinational lane crossbar with per-lane inversion.
// Forward mode: out lane i <- in lane map[i]. Inverse mode: out lane map[i] <- in lane i.
// Inversion is always indexed by the Aurora-side lane i.
module aurora_lane_xbar #(
   parameter int unsigned NUM_LANES = 4,
   parameter int unsigned DATA_W    = 64,
   parameter int unsigned SEL_W     = 2,
   parameter bit          INVERSE   = 1'b0
) (
   input  logic [NUM_LANES*SEL_W-1:0]  lane_map,
   input  logic [NUM_LANES-1:0]        invert,
   input  logic [NUM_LANES*DATA_W-1:0] in_data,
   input  logic [NUM_LANES-1:0]        in_valid,
   output logic [NUM_LANES*DATA_W-1:0] out_data,
   output logic [NUM_LANES-1:0]        out_valid
);

   logic [NUM_LANES-1:0][SEL_W-1:0]  sel;
   logic [NUM_LANES-1:0][DATA_W-1:0] din;
   logic [NUM_LANES-1:0][DATA_W-1:0] dout;

   assign sel      = lane_map;
   assign din      = in_data;
   assign out_data = dout;

   // Compare-based select keeps non-power-of-two lane counts free of out-of-range indexing.
   always_comb begin
      dout      = '0;
      out_valid = '0;
      for (int unsigned i = 0; i < NUM_LANES; i++) begin
         for (int unsigned j = 0; j < NUM_LANES; j++) begin
            if (sel[i] == SEL_W'(j)) begin
               if (!INVERSE) begin
                  dout[i]      = din[j] ^ {DATA_W{invert[i]}};
                  out_valid[i] = in_valid[j];
               end else begin
                  dout[j]      = din[i] ^ {DATA_W{invert[i]}};
                  out_valid[j] = in_valid[i];
               end
            end
         end
      end
   end

endmodule

// File: rtl/aurora_lane_mapper.sv
// Runtime-reconfigurable lane permutation/polarity stage between GT and Aurora lanes.
// Map updates are validated, then applied behind a blanking window of invalid outputs.
module aurora_lane_mapper
   import aurora_lane_pkg::*;
#(
   parameter int unsigned NUM_LANES    = 4,
   parameter int unsigned DATA_W       = 64,
   parameter int unsigned SEL_W        = $clog2(NUM_LANES),
   parameter int unsigned BLANK_CYCLES = 16
) (
   input  logic                        user_clk,
   input  logic                        reset,
   input  logic [NUM_LANES*SEL_W-1:0]  cfg_map,
   input  logic [NUM_LANES-1:0]        cfg_invert,
   input  logic                        cfg_valid,
   output logic                        cfg_ready,
   output logic                        cfg_err,
   output logic                        map_busy,
   output logic [NUM_LANES*SEL_W-1:0]  cur_map,
   input  logic [NUM_LANES*DATA_W-1:0] gt_rx_data,
   input  logic [NUM_LANES-1:0]        gt_rx_valid,
   output logic [NUM_LANES*DATA_W-1:0] au_rx_data,
   output logic [NUM_LANES-1:0]        au_rx_valid,
   input  logic [NUM_LANES*DATA_W-1:0] au_tx_data,
   input  logic [NUM_LANES-1:0]        au_tx_valid,
   output logic [NUM_LANES*DATA_W-1:0] gt_tx_data,
   output logic [NUM_LANES-1:0]        gt_tx_valid
);

   localparam int unsigned CNT_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLANK_CYCLES - 1);
   localparam lane_vec_t IDENT_V = identity_map(NUM_LANES);

   lane_state_e state_q, state_d;
   logic [CNT_W-1:0] cnt_q;

   logic [NUM_LANES-1:0][SEL_W-1:0] ident_map;
   logic [NUM_LANES-1:0][SEL_W-1:0] shadow_map_q;
   logic [NUM_LANES-1:0][SEL_W-1:0] active_map_q;
   logic [NUM_LANES-1:0]            shadow_inv_q;
   logic [NUM_LANES-1:0]            active_inv_q;
   logic                            cfg_err_q;

   lane_vec_t shadow_vec;
   logic      map_ok;
   logic      accept;
   logic      blank_done;

   logic [NUM_LANES*DATA_W-1:0] rx_mapped_data, tx_mapped_data;
   logic [NUM_LANES-1:0]        rx_mapped_valid, tx_mapped_valid;

   for (genvar g = 0; g < NUM_LANES; g++) begin : g_ident
      assign ident_map[g] = IDENT_V[g][SEL_W-1:0];
   end

   assign accept     = (state_q == ST_ACTIVE) && cfg_valid;
   assign blank_done = (state_q == ST_BLANK) && (cnt_q == CNT_LAST);
   assign cur_map    = active_map_q;
   assign cfg_err    = cfg_err_q;

   // Widen the shadow map into the package lane vector and validate it.
   always_comb begin
      shadow_vec = '0;
      for (int unsigned i = 0; i < NUM_LANES; i++) begin
         shadow_vec[i] = IDX_W'(shadow_map_q[i]);
      end
      map_ok = map_is_perm(shadow_vec, NUM_LANES);
   end

   // FSM state register.
   always_ff @(posedge user_clk or posedge reset) begin
      if (reset) state_q <= ST_ACTIVE;
      else       state_q <= state_d;
   end

   // FSM next-state and handshake/status outputs.
   always_comb begin
      state_d   = state_q;
      cfg_ready = 1'b0;
      map_busy  = 1'b0;
      case (state_q)
         ST_ACTIVE: begin
            cfg_ready = 1'b1;
            if (cfg_valid) state_d = ST_CHECK;
         end
         ST_CHECK: begin
            map_busy = 1'b1;
            state_d  = map_ok ? ST_BLANK : ST_ACTIVE;
         end
         ST_BLANK: begin
            map_busy = 1'b1;
            if (cnt_q == CNT_LAST) state_d = ST_ACTIVE;
         end
         default: state_d = ST_ACTIVE;
      endcase
   end

   // Blanking counter, shadow capture, active-map load and error pulse.
   always_ff @(posedge user_clk or posedge reset) begin
      if (reset) begin
         cnt_q        <= '0;
         shadow_map_q <= ident_map;
         shadow_inv_q <= '0;
         active_map_q <= ident_map;
         active_inv_q <= '0;
         cfg_err_q    <= 1'b0;
      end else begin
         cfg_err_q <= (state_q == ST_CHECK) && !map_ok;
         cnt_q     <= ((state_q == ST_BLANK) && !blank_done) ? cnt_q + 1'b1 : '0;
         if (accept) begin
            shadow_map_q <= cfg_map;
            shadow_inv_q <= cfg_invert;
         end
         if (blank_done) begin
            active_map_q <= shadow_map_q;
            active_inv_q <= shadow_inv_q;
         end
      end
   end

   aurora_lane_xbar #(
      .NUM_LANES (NUM_LANES),
      .DATA_W    (DATA_W),
      .SEL_W     (SEL_W),
      .INVERSE   (1'b0)
   ) u_rx_xbar (
      .lane_map  (active_map_q),
      .invert    (active_inv_q),
      .in_data   (gt_rx_data),
      .in_valid  (gt_rx_valid),
      .out_data  (rx_mapped_data),
      .out_valid (rx_mapped_valid)
   );

   aurora_lane_xbar #(
      .NUM_LANES (NUM_LANES),
      .DATA_W    (DATA_W),
      .SEL_W     (SEL_W),
      .INVERSE   (1'b1)
   ) u_tx_xbar (
      .lane_map  (active_map_q),
      .invert    (active_inv_q),
      .in_data   (au_tx_data),
      .in_valid  (au_tx_valid),
      .out_data  (tx_mapped_data),
      .out_valid (tx_mapped_valid)
   );

   // Output registers: mapped data, or zeros/invalid while blanking.
   always_ff @(posedge user_clk or posedge reset) begin
      if (reset) begin
         au_rx_data  <= '0;
         au_rx_valid <= '0;
         gt_tx_data  <= '0;
         gt_tx_valid <= '0;
      end else if (state_q == ST_BLANK) begin
         au_rx_data  <= '0;
         au_rx_valid <= '0;
         gt_tx_data  <= '0;
         gt_tx_valid <= '0;
      end else begin
         au_rx_data  <= rx_mapped_data;
         au_rx_valid <= rx_mapped_valid;
         gt_tx_data  <= tx_mapped_data;
         gt_tx_valid <= tx_mapped_valid;
      end
   end

endmodule

// File: tb/tb_aurora_lane_mapper.sv
// Self-checking bench for aurora_lane_mapper (4-lane default build plus a 2-lane, 1-cycle-blank build).
module tb_aurora_lane_mapper;

   localparam int BC = 16;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // 4-lane instance signals
   logic [3:0][1:0]  cfg_map;
   logic [3:0]       cfg_invert;
   logic             cfg_valid, cfg_ready, cfg_err, map_busy;
   logic [7:0]       cur_map;
   logic [3:0][63:0] gt_rx_data, au_rx_data, au_tx_data, gt_tx_data;
   logic [3:0]       gt_rx_valid, au_rx_valid, au_tx_valid, gt_tx_valid;

   // 2-lane instance signals
   logic [1:0]       cfg_map2, cfg_invert2, cur_map2;
   logic             cfg_valid2, cfg_ready2, cfg_err2, map_busy2;
   logic [1:0][63:0] gt_rx_data2, au_rx_data2, au_tx_data2, gt_tx_data2;
   logic [1:0]       gt_rx_valid2, au_rx_valid2, au_tx_valid2, gt_tx_valid2;

   aurora_lane_mapper #(.NUM_LANES(4), .DATA_W(64), .BLANK_CYCLES(BC)) dut (
      .user_clk(clk), .reset(rst),
      .cfg_map(cfg_map), .cfg_invert(cfg_invert), .cfg_valid(cfg_valid),
      .cfg_ready(cfg_ready), .cfg_err(cfg_err), .map_busy(map_busy), .cur_map(cur_map),
      .gt_rx_data(gt_rx_data), .gt_rx_valid(gt_rx_valid),
      .au_rx_data(au_rx_data), .au_rx_valid(au_rx_valid),
      .au_tx_data(au_tx_data), .au_tx_valid(au_tx_valid),
      .gt_tx_data(gt_tx_data), .gt_tx_valid(gt_tx_valid)
   );

   aurora_lane_mapper #(.NUM_LANES(2), .DATA_W(64), .BLANK_CYCLES(1)) dut2 (
      .user_clk(clk), .reset(rst),
      .cfg_map(cfg_map2), .cfg_invert(cfg_invert2), .cfg_valid(cfg_valid2),
      .cfg_ready(cfg_ready2), .cfg_err(cfg_err2), .map_busy(map_busy2), .cur_map(cur_map2),
      .gt_rx_data(gt_rx_data2), .gt_rx_valid(gt_rx_valid2),
      .au_rx_data(au_rx_data2), .au_rx_valid(au_rx_valid2),
      .au_tx_data(au_tx_data2), .au_tx_valid(au_tx_valid2),
      .gt_tx_data(gt_tx_data2), .gt_tx_valid(gt_tx_valid2)
   );

   int checks = 0;
   int errors = 0;

   // Reference model state: the map the model believes is live.
   logic [3:0][1:0] model_map;
   logic [3:0]      model_inv;
   localparam logic [3:0][1:0] IDENT = {2'd3, 2'd2, 2'd1, 2'd0};

   typedef struct {
      int               phase;
      logic [3:0][63:0] rx_in;
      logic [3:0]       rx_vi;
      logic [3:0][63:0] rx_exp;
      logic [3:0]       rx_ve;
      logic [3:0][63:0] tx_in;
      logic [3:0]       tx_vi;
      logic [3:0][63:0] tx_exp;
      logic [3:0]       tx_ve;
   } vec_t;

   vec_t tbl[4];

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One data cycle: drive random lanes, clock, compare against the model (or zeros if blanking).
   task automatic run_cycle(input bit blank, input bit all_valid, input string tag);
      logic [3:0][63:0] erx, etx;
      logic [3:0]       erv, etv;
      for (int i = 0; i < 4; i++) begin
         gt_rx_data[i] = {$urandom, $urandom};
         au_tx_data[i] = {$urandom, $urandom};
      end
      gt_rx_valid = all_valid ? 4'hF : 4'($urandom);
      au_tx_valid = all_valid ? 4'hF : 4'($urandom);
      @(posedge clk);
      #1;
      erx = '0; etx = '0; erv = '0; etv = '0;
      if (!blank) begin
         for (int i = 0; i < 4; i++) begin
            erx[i]            = gt_rx_data[model_map[i]] ^ {64{model_inv[i]}};
            erv[i]            = gt_rx_valid[model_map[i]];
            etx[model_map[i]] = au_tx_data[i] ^ {64{model_inv[i]}};
            etv[model_map[i]] = au_tx_valid[i];
         end
      end
      chk({tag, "_rxd"}, 256'(au_rx_data), 256'(erx));
      chk({tag, "_rxv"}, 256'(au_rx_valid), 256'(erv));
      chk({tag, "_txd"}, 256'(gt_tx_data), 256'(etx));
      chk({tag, "_txv"}, 256'(gt_tx_valid), 256'(etv));
   endtask

   task automatic apply_vec(input int k);
      gt_rx_data  = tbl[k].rx_in;
      gt_rx_valid = tbl[k].rx_vi;
      au_tx_data  = tbl[k].tx_in;
      au_tx_valid = tbl[k].tx_vi;
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_rxd", k), 256'(au_rx_data), 256'(tbl[k].rx_exp));
      chk($sformatf("tbl%0d_rxv", k), 256'(au_rx_valid), 256'(tbl[k].rx_ve));
      chk($sformatf("tbl%0d_txd", k), 256'(gt_tx_data), 256'(tbl[k].tx_exp));
      chk($sformatf("tbl%0d_txv", k), 256'(gt_tx_valid), 256'(tbl[k].tx_ve));
   endtask

   // Issue a config request at the next edge and check every cycle of the change sequence.
   task automatic do_cfg(input logic [3:0][1:0] nmap, input logic [3:0] ninv,
                         input bit hold, input int abort_at, input string tag);
      logic [3:0][1:0] old_map, exp_cur;
      logic [3:0]      old_inv;
      int              seen[4];
      bit              ok, exp_busy, exp_err;
      int              gaps, last_m, w;
      for (int k = 0; k < 4; k++) seen[k] = 0;
      for (int i = 0; i < 4; i++) seen[nmap[i]]++;
      ok = 1'b1;
      for (int k = 0; k < 4; k++) if (seen[k] != 1) ok = 1'b0;
      old_map    = model_map;
      old_inv    = model_inv;
      gaps       = 0;
      cfg_map    = nmap;
      cfg_invert = ninv;
      cfg_valid  = 1'b1;
      last_m     = ok ? BC + 2 : 2;
      for (int m = 0; m <= last_m; m++) begin
         if (m == abort_at) return;
         if (ok && m >= 2) begin
            model_map = nmap;
            model_inv = ninv;
         end else begin
            model_map = old_map;
            model_inv = old_inv;
         end
         run_cycle(ok && (m >= 2) && (m <= BC + 1), 1'b1, $sformatf("%s_m%0d", tag, m));
         if (au_rx_valid == 4'h0) gaps++;
         if (ok) begin
            exp_busy = (m <= BC) || (hold && m == BC + 2);
            exp_cur  = (m <= BC) ? old_map : nmap;
            exp_err  = 1'b0;
         end else begin
            exp_busy = (m == 0);
            exp_cur  = old_map;
            exp_err  = (m == 1);
         end
         chk($sformatf("%s_m%0d_busy", tag, m), 256'(map_busy), 256'(exp_busy));
         chk($sformatf("%s_m%0d_ready", tag, m), 256'(cfg_ready), 256'(!exp_busy));
         chk($sformatf("%s_m%0d_err", tag, m), 256'(cfg_err), 256'(exp_err));
         chk($sformatf("%s_m%0d_cur", tag, m), 256'(cur_map), 256'(exp_cur));
         if (!hold) cfg_valid = 1'b0;
      end
      chk({tag, "_gap_len"}, 256'(gaps), ok ? 256'(BC) : 256'(0));
      if (hold) begin
         cfg_valid = 1'b0;
         w = 0;
         while (map_busy && w < 60) begin
            @(posedge clk);
            #1;
            w++;
         end
         chk({tag, "_settle"}, 256'(map_busy), 256'(0));
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [3:0][1:0] rmap;
      int              arr[4];
      int              j, tmp;

      rst = 1'b1;
      cfg_map = IDENT; cfg_invert = '0; cfg_valid = 1'b0;
      gt_rx_data = '0; gt_rx_valid = '0; au_tx_data = '0; au_tx_valid = '0;
      cfg_map2 = 2'b10; cfg_invert2 = '0; cfg_valid2 = 1'b0;
      gt_rx_data2 = '0; gt_rx_valid2 = '0; au_tx_data2 = '0; au_tx_valid2 = '0;
      model_map = IDENT;
      model_inv = '0;

      tbl[0] = '{0, {64'h1003, 64'h1002, 64'h1001, 64'h1000}, 4'hF,
                    {64'h1003, 64'h1002, 64'h1001, 64'h1000}, 4'hF,
                    {64'h2003, 64'h2002, 64'h2001, 64'h2000}, 4'hF,
                    {64'h2003, 64'h2002, 64'h2001, 64'h2000}, 4'hF};
      tbl[1] = '{0, {64'hFFFF_0000_FFFF_0000, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234_5678_9ABC_DEF0}, 4'b0101,
                    {64'hFFFF_0000_FFFF_0000, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234_5678_9ABC_DEF0}, 4'b0101,
                    {64'h5, 64'h6, 64'h7, 64'h8}, 4'b1010,
                    {64'h5, 64'h6, 64'h7, 64'h8}, 4'b1010};
      tbl[2] = '{1, {64'h13, 64'h12, 64'h11, 64'h10}, 4'b0011,
                    {64'h10, 64'h11, 64'h12, 64'hFFFF_FFFF_FFFF_FFEC}, 4'b1100,
                    {64'h23, 64'h22, 64'h21, 64'h20}, 4'b0001,
                    {64'hFFFF_FFFF_FFFF_FFDF, 64'h21, 64'h22, 64'h23}, 4'b1000};
      tbl[3] = '{1, {64'h1003, 64'h1002, 64'h1001, 64'h1000}, 4'hF,
                    {64'h1000, 64'h1001, 64'h1002, 64'hFFFF_FFFF_FFFF_EFFC}, 4'hF,
                    {64'h2003, 64'h2002, 64'h2001, 64'h2000}, 4'hF,
                    {64'hFFFF_FFFF_FFFF_DFFF, 64'h2001, 64'h2002, 64'h2003}, 4'hF};

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_rxd", 256'(au_rx_data), 256'(0));
      chk("rst_rxv", 256'(au_rx_valid), 256'(0));
      chk("rst_txd", 256'(gt_tx_data), 256'(0));
      chk("rst_txv", 256'(gt_tx_valid), 256'(0));
      chk("rst_cur", 256'(cur_map), 256'(8'hE4));
      chk("rst_busy", 256'(map_busy), 256'(0));
      chk("rst_err", 256'(cfg_err), 256'(0));
      chk("rst_ready", 256'(cfg_ready), 256'(1));
      @(negedge clk);
      rst = 1'b0;

      // Identity map
      for (int k = 0; k < 4; k++) if (tbl[k].phase == 0) apply_vec(k);
      for (int n = 0; n < 5; n++) run_cycle(1'b0, 1'b0, $sformatf("id_rand%0d", n));

      // Reversed map, lane 0 inverted
      do_cfg({2'd0, 2'd1, 2'd2, 2'd3}, 4'b0001, 1'b0, -1, "rev");
      for (int k = 0; k < 4; k++) if (tbl[k].phase == 1) apply_vec(k);

      // Duplicate-lane map is rejected; reversed map stays live
      do_cfg({2'd3, 2'd2, 2'd0, 2'd0}, 4'b1111, 1'b0, -1, "dup");
      apply_vec(3);

      // cfg_valid held through the whole change
      do_cfg({2'd2, 2'd3, 2'd0, 2'd1}, 4'b1010, 1'b1, -1, "hold");
      for (int n = 0; n < 4; n++) run_cycle(1'b0, 1'b0, $sformatf("hold_rand%0d", n));

      // Randomized maps, some with duplicates
      for (int r = 0; r < 6; r++) begin
         for (int k = 0; k < 4; k++) arr[k] = k;
         for (int k = 3; k > 0; k--) begin
            j = $urandom_range(k, 0);
            tmp = arr[k]; arr[k] = arr[j]; arr[j] = tmp;
         end
         if ($urandom_range(3, 0) == 0) begin
            j = $urandom_range(3, 1);
            arr[j] = arr[j - 1];
         end
         for (int k = 0; k < 4; k++) rmap[k] = 2'(arr[k]);
         do_cfg(rmap, 4'($urandom), 1'b0, -1, $sformatf("rnd%0d", r));
         for (int n = 0; n < 8; n++) run_cycle(1'b0, 1'b0, $sformatf("rnd%0d_d%0d", r, n));
      end

      // Reset during BLANK cycle 5
      do_cfg({2'd0, 2'd1, 2'd2, 2'd3}, 4'b0110, 1'b0, 6, "abort");
      cfg_valid = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      chk("arst_rxd", 256'(au_rx_data), 256'(0));
      chk("arst_rxv", 256'(au_rx_valid), 256'(0));
      chk("arst_txv", 256'(gt_tx_valid), 256'(0));
      chk("arst_cur", 256'(cur_map), 256'(8'hE4));
      chk("arst_busy", 256'(map_busy), 256'(0));
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_map = IDENT;
      model_inv = '0;
      #1;
      chk("arst_ready", 256'(cfg_ready), 256'(1));
      for (int n = 0; n < 3; n++) begin
         run_cycle(1'b0, 1'b0, $sformatf("post_rst%0d", n));
         chk($sformatf("post_rst%0d_err", n), 256'(cfg_err), 256'(0));
      end

      // 2-lane, single blank cycle, swap map {1,0}
      chk("l2_cur_id", 256'(cur_map2), 256'(2'b10));
      gt_rx_data2 = {64'h2001, 64'h2000}; gt_rx_valid2 = 2'b11;
      au_tx_data2 = {64'h3001, 64'h3000}; au_tx_valid2 = 2'b11;
      cfg_map2 = 2'b01; cfg_invert2 = 2'b00; cfg_valid2 = 1'b1;
      @(posedge clk); #1;
      chk("l2_m0_rxd", 256'(au_rx_data2), 256'({64'h2001, 64'h2000}));
      chk("l2_m0_busy", 256'(map_busy2), 256'(1));
      cfg_valid2 = 1'b0;
      @(posedge clk); #1;
      chk("l2_m1_rxv", 256'(au_rx_valid2), 256'(2'b11));
      chk("l2_m1_txd", 256'(gt_tx_data2), 256'({64'h3001, 64'h3000}));
      @(posedge clk); #1;
      chk("l2_m2_rxv", 256'(au_rx_valid2), 256'(0));
      chk("l2_m2_rxd", 256'(au_rx_data2), 256'(0));
      chk("l2_m2_txv", 256'(gt_tx_valid2), 256'(0));
      chk("l2_m2_busy", 256'(map_busy2), 256'(0));
      chk("l2_m2_cur", 256'(cur_map2), 256'(2'b01));
      @(posedge clk); #1;
      chk("l2_m3_rxd", 256'(au_rx_data2), 256'({64'h2000, 64'h2001}));
      chk("l2_m3_rxv", 256'(au_rx_valid2), 256'(2'b11));
      chk("l2_m3_txd", 256'(gt_tx_data2), 256'({64'h3000, 64'h3001}));
      chk("l2_m3_err", 256'(cfg_err2), 256'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
